// File: rtl/ls_queue_pkg.sv
// Shared definitions for the load/store queue: op encoding, tag constants
// and the per-entry record held in the circular buffer.
package ls_queue_pkg;

    // Storage widths of the entry record; instance parameters must not exceed these.
    localparam int LSQ_OP_W  = 6;
    localparam int LSQ_XLEN  = 32;
    localparam int LSQ_TAG_W = 5;

    // Loads occupy the low end of the encoding so a single compare classifies an op.
    typedef enum logic [LSQ_OP_W-1:0] {
        OP_LB  = 6'd0,
        OP_LH  = 6'd1,
        OP_LW  = 6'd2,
        OP_LBU = 6'd3,
        OP_LHU = 6'd4,
        OP_SB  = 6'd5,
        OP_SH  = 6'd6,
        OP_SW  = 6'd7
    } lsq_op_e;

    localparam lsq_op_e OP_LAST_LOAD = OP_LHU;

    // Tag 0 means "operand already valid / no request".
    localparam logic [LSQ_TAG_W-1:0] ZERO_TAG = '0;

    typedef struct packed {
        logic [LSQ_OP_W-1:0]  op;
        logic [LSQ_XLEN-1:0]  v1;
        logic [LSQ_XLEN-1:0]  v2;
        logic [LSQ_TAG_W-1:0] q1;
        logic [LSQ_TAG_W-1:0] q2;
        logic [LSQ_XLEN-1:0]  imm;
        logic [LSQ_TAG_W-1:0] tag;
        logic                 committed;
        logic                 req_sent;
    } lsq_entry;

    function automatic logic is_load_op(input logic [LSQ_OP_W-1:0] op);
        return op <= OP_LAST_LOAD;
    endfunction

endpackage

// File: rtl/ls_queue_cdb_match.sv
// One-operand CDB snoop: compares a waiting tag against every broadcast port
// and returns the data of the lowest-numbered matching port.
module lsq_cdb_match
    import ls_queue_pkg::*;
#(
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 5,
    parameter int XLEN    = 32
) (
    input  logic [TAG_W-1:0]         tag_i,
    input  logic [NUM_CDB-1:0]       cdb_valid_i,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag_i,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_data_i,
    output logic                     hit_o,
    output logic [XLEN-1:0]          data_o
);

    // Scan from the highest port down so the lowest matching index is written last.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (cdb_valid_i[p] && (tag_i != TAG_W'(ZERO_TAG)) &&
                (cdb_tag_i[p*TAG_W +: TAG_W] == tag_i)) begin
                hit_o  = 1'b1;
                data_o = cdb_data_i[p*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/ls_queue.sv
// In-order load/store queue between dispatch and the memory execution unit.
// Loads issue from head once ready; stores ask the ROB for commit first and
// issue only once committed. Committed stores survive a flush.
// Optional feature: define LSQ_PERF_EN to build the stall/issue counters.
module ls_queue
    import ls_queue_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int TAG_W       = 5,
    parameter int XLEN        = 32,
    parameter int OP_W        = 6,
    parameter int NUM_CDB     = 2,
    parameter int FULL_MARGIN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       dsp_valid,
    input  logic [OP_W-1:0]            dsp_op,
    input  logic [XLEN-1:0]            dsp_v1,
    input  logic [XLEN-1:0]            dsp_v2,
    input  logic [TAG_W-1:0]           dsp_q1,
    input  logic [TAG_W-1:0]           dsp_q2,
    input  logic [XLEN-1:0]            dsp_imm,
    input  logic [TAG_W-1:0]           dsp_tag,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]    cdb_data,
    input  logic                       commit_valid,
    input  logic [TAG_W-1:0]           commit_tag,
    output logic [TAG_W-1:0]           st_req_tag,
    input  logic                       ex_busy,
    output logic                       ex_valid,
    output logic [OP_W-1:0]            ex_op,
    output logic [XLEN-1:0]            ex_addr,
    output logic [XLEN-1:0]            ex_wdata,
    output logic [TAG_W-1:0]           ex_tag,
    output logic [31:0]                perf_stall_cnt,
    output logic [31:0]                perf_issue_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    lsq_entry          entries_q [DEPTH];
    lsq_entry          entries_d [DEPTH];
    lsq_entry          disp_entry;
    lsq_entry          head_e;
    logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d, prefix, kept;
    logic [DEPTH-1:0]  valid, hit1, hit2;
    logic [XLEN-1:0]   data1 [DEPTH];
    logic [XLEN-1:0]   data2 [DEPTH];
    logic              dsp_hit1, dsp_hit2, run;
    logic [XLEN-1:0]   dsp_data1, dsp_data2;
    logic              head_ready, head_is_load, pop, push, req_fire;
    logic              ex_valid_q, ex_valid_d;
    logic [OP_W-1:0]   ex_op_q, ex_op_d;
    logic [XLEN-1:0]   ex_addr_q, ex_addr_d, ex_wdata_q, ex_wdata_d;
    logic [TAG_W-1:0]  ex_tag_q, ex_tag_d, st_req_tag_q, st_req_tag_d;

    assign full_o  = int'(count_q) >= (DEPTH - FULL_MARGIN);
    assign count_o = count_q;

    // Per-entry wakeup snoopers plus occupancy mask (offset from head below count).
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign valid[gi] = {1'b0, IDX_W'(gi) - head_q} < count_q;

        lsq_cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .XLEN(XLEN)) u_m1 (
            .tag_i(entries_q[gi].q1[TAG_W-1:0]), .cdb_valid_i(cdb_valid),
            .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
            .hit_o(hit1[gi]), .data_o(data1[gi]));

        lsq_cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .XLEN(XLEN)) u_m2 (
            .tag_i(entries_q[gi].q2[TAG_W-1:0]), .cdb_valid_i(cdb_valid),
            .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
            .hit_o(hit2[gi]), .data_o(data2[gi]));
    end

    // Dispatch-time bypass so an operand broadcast in the dispatch cycle is not missed.
    lsq_cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .XLEN(XLEN)) u_dsp_m1 (
        .tag_i(dsp_q1), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
        .cdb_data_i(cdb_data), .hit_o(dsp_hit1), .data_o(dsp_data1));

    lsq_cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .XLEN(XLEN)) u_dsp_m2 (
        .tag_i(dsp_q2), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
        .cdb_data_i(cdb_data), .hit_o(dsp_hit2), .data_o(dsp_data2));

    // Build the record written at tail, folding in any same-cycle broadcast.
    always_comb begin
        disp_entry = '0;
        disp_entry.op[OP_W-1:0]   = dsp_op;
        disp_entry.v1[XLEN-1:0]   = dsp_hit1 ? dsp_data1 : dsp_v1;
        disp_entry.v2[XLEN-1:0]   = dsp_hit2 ? dsp_data2 : dsp_v2;
        disp_entry.q1[TAG_W-1:0]  = dsp_hit1 ? '0 : dsp_q1;
        disp_entry.q2[TAG_W-1:0]  = dsp_hit2 ? '0 : dsp_q2;
        disp_entry.imm[XLEN-1:0]  = dsp_imm;
        disp_entry.tag[TAG_W-1:0] = dsp_tag;
    end

    // Head issue decision: only the oldest entry may leave the queue.
    always_comb begin
        head_e       = entries_q[head_q];
        head_is_load = is_load_op(head_e.op);
        head_ready   = (count_q != '0) && !ex_busy && (head_e.q1 == '0) && (head_e.q2 == '0);
        pop          = head_ready && (head_is_load || head_e.committed);
        req_fire     = head_ready && !head_is_load && !head_e.committed &&
                       !head_e.req_sent && !flush;
        push         = dsp_valid && !full_o && !flush;
    end

    // Length of the committed run starting at head; that run survives a flush.
    always_comb begin
        prefix = '0;
        run    = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (run && (CNT_W'(k) < count_q) && entries_q[head_q + IDX_W'(k)].committed)
                prefix = prefix + CNT_W'(1);
            else
                run = 1'b0;
        end
        kept = (pop && (prefix != '0)) ? prefix - CNT_W'(1) : prefix;
    end

    // Next-state for entries, pointers, occupancy and the issue/request outputs.
    always_comb begin
        entries_d    = entries_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        ex_valid_d   = 1'b0;
        ex_op_d      = ex_op_q;
        ex_addr_d    = ex_addr_q;
        ex_wdata_d   = ex_wdata_q;
        ex_tag_d     = ex_tag_q;
        st_req_tag_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                if (hit1[i]) begin
                    entries_d[i].v1[XLEN-1:0] = data1[i];
                    entries_d[i].q1           = '0;
                end
                if (hit2[i]) begin
                    entries_d[i].v2[XLEN-1:0] = data2[i];
                    entries_d[i].q2           = '0;
                end
                if (commit_valid && (commit_tag != '0) &&
                    (entries_q[i].tag[TAG_W-1:0] == commit_tag))
                    entries_d[i].committed = 1'b1;
            end
        end
        if (req_fire) begin
            st_req_tag_d               = head_e.tag[TAG_W-1:0];
            entries_d[head_q].req_sent = 1'b1;
        end
        if (pop) begin
            ex_valid_d = 1'b1;
            ex_op_d    = head_e.op[OP_W-1:0];
            ex_addr_d  = head_e.v1[XLEN-1:0] + head_e.imm[XLEN-1:0];
            ex_wdata_d = head_is_load ? '0 : head_e.v2[XLEN-1:0];
            ex_tag_d   = head_e.tag[TAG_W-1:0];
            head_d     = head_q + IDX_W'(1);
        end
        if (flush) begin
            tail_d  = head_q + prefix[IDX_W-1:0];
            count_d = kept;
        end else begin
            if (push) begin
                entries_d[tail_q] = disp_entry;
                tail_d            = tail_q + IDX_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage; validity comes from head/count so it needs no reset.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    // Pointer, occupancy and registered-output state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            ex_valid_q   <= 1'b0;
            ex_op_q      <= '0;
            ex_addr_q    <= '0;
            ex_wdata_q   <= '0;
            ex_tag_q     <= '0;
            st_req_tag_q <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            ex_valid_q   <= ex_valid_d;
            ex_op_q      <= ex_op_d;
            ex_addr_q    <= ex_addr_d;
            ex_wdata_q   <= ex_wdata_d;
            ex_tag_q     <= ex_tag_d;
            st_req_tag_q <= st_req_tag_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_op      = ex_op_q;
    assign ex_addr    = ex_addr_q;
    assign ex_wdata   = ex_wdata_q;
    assign ex_tag     = ex_tag_q;
    assign st_req_tag = st_req_tag_q;

`ifdef LSQ_PERF_EN
    logic [31:0] perf_stall_q, perf_issue_q;

    // Stall = occupied but head not leaving; issue counted on the edge ex_valid rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_issue_q <= '0;
        end else begin
            if ((count_q != '0) && !pop)
                perf_stall_q <= perf_stall_q + 32'd1;
            if (pop)
                perf_issue_q <= perf_issue_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_issue_cnt = perf_issue_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_issue_cnt = '0;
`endif

endmodule

// File: tb/tb_ls_queue.sv
// Scenario bench for ls_queue (DEPTH=4). Expected issues are queued when
// stimulus is driven and checked by a monitor whenever ex_valid is seen.
module tb_ls_queue;
    import ls_queue_pkg::*;

    localparam int DEPTH = 4, TAG_W = 5, XLEN = 32, OP_W = 6, NUM_CDB = 2, FULL_MARGIN = 1;
`ifdef LSQ_PERF_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst, flush, dsp_valid, full_o, commit_valid, ex_busy, ex_valid;
    logic [OP_W-1:0]          dsp_op, ex_op;
    logic [XLEN-1:0]          dsp_v1, dsp_v2, dsp_imm, ex_addr, ex_wdata;
    logic [TAG_W-1:0]         dsp_q1, dsp_q2, dsp_tag, commit_tag, st_req_tag, ex_tag;
    logic [$clog2(DEPTH):0]   count_o;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_data;
    logic [31:0]              perf_stall_cnt, perf_issue_cnt;

    ls_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .OP_W(OP_W),
               .NUM_CDB(NUM_CDB), .FULL_MARGIN(FULL_MARGIN)) dut (
        .clk(clk), .rst(rst), .flush(flush), .dsp_valid(dsp_valid), .dsp_op(dsp_op),
        .dsp_v1(dsp_v1), .dsp_v2(dsp_v2), .dsp_q1(dsp_q1), .dsp_q2(dsp_q2),
        .dsp_imm(dsp_imm), .dsp_tag(dsp_tag), .full_o(full_o), .count_o(count_o),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .st_req_tag(st_req_tag),
        .ex_busy(ex_busy), .ex_valid(ex_valid), .ex_op(ex_op), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_tag(ex_tag),
        .perf_stall_cnt(perf_stall_cnt), .perf_issue_cnt(perf_issue_cnt));

    typedef struct {
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  wdata;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;

    // Scoreboard monitor: every issue pulse must match the oldest expected issue.
    always @(negedge clk) begin
        if (!rst && ex_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL issue_unexpected: got tag %0d addr %h, required no issue", ex_tag, ex_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if (ex_op !== mon_e.op || ex_addr !== mon_e.addr || ex_tag !== mon_e.tag ||
                    (mon_e.op > OP_LAST_LOAD && ex_wdata !== mon_e.wdata))
                    $display("FAIL issue: got op %0d addr %h wdata %h tag %0d, required op %0d addr %h wdata %h tag %0d",
                             ex_op, ex_addr, ex_wdata, ex_tag, mon_e.op, mon_e.addr, mon_e.wdata, mon_e.tag);
                else begin
                    passes++;
                    $display("issue op %0d addr %h wdata %h tag %0d ok", ex_op, ex_addr, ex_wdata, ex_tag);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dispatch(input logic [OP_W-1:0] op, input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2,
                            input logic [TAG_W-1:0] q1, input logic [TAG_W-1:0] q2,
                            input logic [XLEN-1:0] imm, input logic [TAG_W-1:0] tag);
        dsp_valid = 1'b1; dsp_op = op; dsp_v1 = v1; dsp_v2 = v2;
        dsp_q1 = q1; dsp_q2 = q2; dsp_imm = imm; dsp_tag = tag;
        tick();
        dsp_valid = 1'b0;
    endtask

    task automatic expect_issue(input logic [OP_W-1:0] op, input logic [XLEN-1:0] addr,
                                input logic [XLEN-1:0] wdata, input logic [TAG_W-1:0] tag);
        exp_t e;
        e.op = op; e.addr = addr; e.wdata = wdata; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (count_o !== 0) $display("FAIL reset_count: got %0d required 0", count_o); else passes++;
        checks++; if (full_o !== 1'b0) $display("FAIL reset_full: got %0b required 0", full_o); else passes++;
        checks++; if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid: got %0b required 0", ex_valid); else passes++;
        checks++; if (st_req_tag !== 0) $display("FAIL reset_st_req: got %0d required 0", st_req_tag); else passes++;
        checks++; if (ex_addr !== 0 || ex_tag !== 0) $display("FAIL reset_ex_out: got addr %h tag %0d required 0", ex_addr, ex_tag); else passes++;
        checks++; if (perf_stall_cnt !== 0 || perf_issue_cnt !== 0) $display("FAIL reset_perf: got %0d/%0d required 0", perf_stall_cnt, perf_issue_cnt); else passes++;
        rst = 1'b0;
        $display("reset done");
    endtask

    task automatic test_full();
        dispatch(OP_LW, 32'h0, 32'h0, 5'd9, 5'd0, 32'h0, 5'd1);
        dispatch(OP_LW, 32'h0, 32'h0, 5'd9, 5'd0, 32'h4, 5'd2);
        dispatch(OP_LW, 32'h0, 32'h0, 5'd9, 5'd0, 32'h8, 5'd3);
        checks++; if (count_o !== 3) $display("FAIL full_count: got %0d required 3", count_o); else passes++;
        checks++; if (full_o !== 1'b1) $display("FAIL full_flag: got %0b required 1", full_o); else passes++;
        dispatch(OP_LW, 32'h0, 32'h0, 5'd9, 5'd0, 32'hC, 5'd4);
        checks++; if (count_o !== 3) $display("FAIL full_ignored: got %0d required 3", count_o); else passes++;
        expect_issue(OP_LW, 32'h2000, 32'h0, 5'd1);
        expect_issue(OP_LW, 32'h2004, 32'h0, 5'd2);
        expect_issue(OP_LW, 32'h2008, 32'h0, 5'd3);
        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd9}; cdb_data = {32'h0, 32'h2000};
        tick();
        cdb_valid = 2'b00;
        tick();
        checks++; if (full_o !== 1'b0 || count_o !== 2) $display("FAIL full_after_pop: got full %0b count %0d required 0/2", full_o, count_o); else passes++;
        tick(); tick();
        checks++; if (count_o !== 0) $display("FAIL full_drain: got %0d required 0", count_o); else passes++;
        $display("full test done");
    endtask

    task automatic test_load();
        expect_issue(OP_LW, 32'h00000FFC, 32'h0, 5'd6);
        dispatch(OP_LW, 32'h1000, 32'h0, 5'd0, 5'd0, 32'hFFFFFFFC, 5'd6);
        checks++; if (ex_valid !== 1'b0) $display("FAIL load_early: got %0b required 0", ex_valid); else passes++;
        tick();
        checks++; if (ex_valid !== 1'b1) $display("FAIL load_latency: got %0b required 1", ex_valid); else passes++;
        tick();
        checks++; if (ex_valid !== 1'b0) $display("FAIL load_pulse: got %0b required 0", ex_valid); else passes++;
        $display("load test done");
    endtask

    task automatic test_store_commit();
        dispatch(OP_SW, 32'h100, 32'hDEADBEEF, 5'd0, 5'd0, 32'h4, 5'd5);
        checks++; if (st_req_tag !== 0) $display("FAIL st_req_early: got %0d required 0", st_req_tag); else passes++;
        tick();
        checks++; if (st_req_tag !== 5) $display("FAIL st_req: got %0d required 5", st_req_tag); else passes++;
        commit_valid = 1'b1; commit_tag = 5'd5;
        expect_issue(OP_SW, 32'h104, 32'hDEADBEEF, 5'd5);
        tick();
        commit_valid = 1'b0;
        checks++; if (st_req_tag !== 0) $display("FAIL st_req_once: got %0d required 0", st_req_tag); else passes++;
        checks++; if (ex_valid !== 1'b0) $display("FAIL store_early: got %0b required 0", ex_valid); else passes++;
        tick();
        checks++; if (ex_valid !== 1'b1) $display("FAIL store_issue: got %0b required 1", ex_valid); else passes++;
        checks++; if (st_req_tag !== 0 || count_o !== 0) $display("FAIL store_after: got req %0d count %0d required 0/0", st_req_tag, count_o); else passes++;
        $display("store test done");
    endtask

    task automatic test_bypass();
        cdb_valid = 2'b10; cdb_tag = {5'd7, 5'd0}; cdb_data = {32'hAB, 32'h0};
        expect_issue(OP_LW, 32'hBB, 32'h0, 5'd8);
        dispatch(OP_LW, 32'h0, 32'h0, 5'd7, 5'd0, 32'h10, 5'd8);
        cdb_valid = 2'b00;
        tick();
        checks++; if (ex_valid !== 1'b1) $display("FAIL bypass_issue: got %0b required 1", ex_valid); else passes++;
        $display("bypass test done");
    endtask

    task automatic test_wakeup_priority();
        dispatch(OP_LW, 32'h0, 32'h0, 5'd11, 5'd0, 32'h20, 5'd10);
        cdb_valid = 2'b11; cdb_tag = {5'd11, 5'd11}; cdb_data = {32'h400, 32'h300};
        expect_issue(OP_LW, 32'h320, 32'h0, 5'd10);
        tick();
        cdb_valid = 2'b00;
        checks++; if (ex_valid !== 1'b0) $display("FAIL wake_early: got %0b required 0", ex_valid); else passes++;
        tick();
        checks++; if (ex_valid !== 1'b1) $display("FAIL wake_issue: got %0b required 1", ex_valid); else passes++;
        $display("wakeup test done");
    endtask

    task automatic test_flush();
        dispatch(OP_SW, 32'h500, 32'h0, 5'd0, 5'd13, 32'h0, 5'd12);
        dispatch(OP_LW, 32'h600, 32'h0, 5'd0, 5'd0, 32'h0, 5'd14);
        dispatch(OP_SW, 32'h700, 32'h1, 5'd0, 5'd0, 32'h0, 5'd15);
        commit_valid = 1'b1; commit_tag = 5'd12;
        tick();
        commit_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (count_o !== 1) $display("FAIL flush_count: got %0d required 1", count_o); else passes++;
        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd13}; cdb_data = {32'h0, 32'h77};
        expect_issue(OP_SW, 32'h500, 32'h77, 5'd12);
        tick();
        cdb_valid = 2'b00;
        checks++; if (ex_valid !== 1'b0) $display("FAIL flush_early: got %0b required 0", ex_valid); else passes++;
        tick();
        checks++; if (ex_valid !== 1'b1 || count_o !== 0) $display("FAIL flush_store: got valid %0b count %0d required 1/0", ex_valid, count_o); else passes++;
        tick(); tick(); tick();
        $display("flush test done");
    endtask

    task automatic test_busy_stall();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ex_busy = 1'b1;
        dispatch(OP_LW, 32'h40, 32'h0, 5'd0, 5'd0, 32'h2, 5'd16);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (ex_valid !== 1'b0) $display("FAIL busy_hold[%0d]: got %0b required 0", c, ex_valid); else passes++;
        end
        ex_busy = 1'b0;
        expect_issue(OP_LW, 32'h42, 32'h0, 5'd16);
        tick();
        checks++; if (ex_valid !== 1'b1) $display("FAIL busy_release: got %0b required 1", ex_valid); else passes++;
        checks++; if (perf_stall_cnt !== 32'(3 * PERF_ON)) $display("FAIL perf_stall: got %0d required %0d", perf_stall_cnt, 3 * PERF_ON); else passes++;
        checks++; if (perf_issue_cnt !== 32'(PERF_ON)) $display("FAIL perf_issue: got %0d required %0d", perf_issue_cnt, PERF_ON); else passes++;
        tick();
        $display("busy test done");
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; dsp_valid = 1'b0; dsp_op = '0; dsp_v1 = '0; dsp_v2 = '0;
        dsp_q1 = '0; dsp_q2 = '0; dsp_imm = '0; dsp_tag = '0; cdb_valid = '0; cdb_tag = '0;
        cdb_data = '0; commit_valid = 1'b0; commit_tag = '0; ex_busy = 1'b0;
        test_reset();
        test_full();
        test_load();
        test_store_commit();
        test_bypass();
        test_wakeup_priority();
        test_flush();
        test_busy_stall();
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
